ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_bitstream_loader.sv | 160 ++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words onto a ccff chain, gates the chain clock,
// captures the previous chain contents as readback and holds the fabric isolated until done.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rdbk_data,
    output logic              rdbk_valid,
    output logic              busy,
    output logic              done,
    output logic              isol_n
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WB_W-1:0]   r_wbit;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_rdbk;
    logic [WORD_W-1:0] r_rdbk_data;
    logic              r_rdbk_valid;

    logic              w_last_bit;
    logic              w_last_wbit;
    logic              w_start_ok;
    logic [WORD_W-1:0] w_cap;

    assign w_last_bit  = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_last_wbit = (r_wbit == WB_W'(WORD_W - 1));
    assign w_start_ok  = start && !abort;
    // Readback word with the tail bit of this edge merged at its capture position.
    assign w_cap       = r_rdbk | (WORD_W'(ccff_tail) << r_wbit);

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        isol_n        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (cfg_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = r_word[0];
                busy          = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end else if (w_last_wbit) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                isol_n = 1'b1;
                if (w_start_ok) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_bit_cnt    <= '0;
            r_wbit       <= '0;
            r_word       <= '0;
            r_rdbk       <= '0;
            r_rdbk_data  <= '0;
            r_rdbk_valid <= 1'b0;
        end else begin
            r_rdbk_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_bit_cnt <= '0;
                        r_wbit    <= '0;
                        r_rdbk    <= '0;
                    end
                end
                S_LOAD: begin
                    if (!abort && cfg_valid) begin
                        r_word <= cfg_data;
                        r_wbit <= '0;
                        r_rdbk <= '0;
                    end
                end
                S_SHIFT: begin
                    // Abort leaves the partial readback word unpublished; the next start clears it.
                    if (!abort) begin
                        r_word    <= r_word >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_bit || w_last_wbit) begin
                            r_rdbk_data  <= w_cap;
                            r_rdbk_valid <= 1'b1;
                            r_wbit       <= '0;
                            r_rdbk       <= '0;
                        end else begin
                            r_wbit <= r_wbit + 1'b1;
                            r_rdbk <= w_cap;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdbk_data  = r_rdbk_data;
    assign rdbk_valid = r_rdbk_valid;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 4-bit and a 20-bit chain, each with a
// physical chain register, checked against a pass-level bitstream/readback model.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam int NI = 2;

    logic       prog_clk = 1'b0;
    logic       rst       [NI];
    logic       start     [NI];
    logic       abort_s   [NI];
    logic [7:0] cfg_data  [NI];
    logic       cfg_valid [NI];
    logic       cfg_ready [NI];
    logic       head      [NI];
    logic       shen      [NI];
    logic       tail      [NI];
    logic [7:0] rd        [NI];
    logic       rv        [NI];
    logic       busy      [NI];
    logic       done      [NI];
    logic       isol      [NI];
    logic [19:0] chain    [NI] = '{default: '0};

    bit         exp_head [NI][$];
    logic [7:0] exp_rdbk [NI][$];
    bit         chain_q  [NI][$];
    bit         got_head [NI][$];
    logic [7:0] got_rdbk [NI][$];
    int         shift_cnt [NI];
    int         busy_cnt  [NI];
    int         rv_cnt    [NI];

    int errors = 0;
    int checks = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(4), .WORD_W(8)) u_dut4 (
        .prog_clk(prog_clk), .prog_reset(rst[0]), .start(start[0]), .abort(abort_s[0]),
        .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .ccff_head(head[0]), .ccff_shift_en(shen[0]), .ccff_tail(tail[0]),
        .rdbk_data(rd[0]), .rdbk_valid(rv[0]), .busy(busy[0]), .done(done[0]), .isol_n(isol[0])
    );

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
        .prog_clk(prog_clk), .prog_reset(rst[1]), .start(start[1]), .abort(abort_s[1]),
        .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .ccff_head(head[1]), .ccff_shift_en(shen[1]), .ccff_tail(tail[1]),
        .rdbk_data(rd[1]), .rdbk_valid(rv[1]), .busy(busy[1]), .done(done[1]), .isol_n(isol[1])
    );

    // Downstream chain: clocked only when the gate enable is high; head enters bit 0.
    always @(posedge prog_clk) begin
        for (int k = 0; k < NI; k++) begin
            if (shen[k]) chain[k] <= {chain[k][18:0], head[k]};
        end
    end
    assign tail[0] = chain[0][3];
    assign tail[1] = chain[1][19];

    function automatic int len_of(input int k);
        return (k == 0) ? 4 : 20;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [31:0] pack_head(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < got_head[k].size() && i < 32; i++) v[i] = got_head[k][i];
        return v;
    endfunction

    task automatic resync_chain(input int k);
        int L;
        L = len_of(k);
        chain_q[k].delete();
        for (int i = L - 1; i >= 0; i--) chain_q[k].push_back(chain[k][i]);
    endtask

    task automatic chk_reset_vals(input int k, input string tag);
        chk($sformatf("%s dut%0d cfg_ready", tag, k), cfg_ready[k], 0);
        chk($sformatf("%s dut%0d ccff_head", tag, k), head[k], 0);
        chk($sformatf("%s dut%0d shift_en", tag, k), shen[k], 0);
        chk($sformatf("%s dut%0d rdbk_data", tag, k), rd[k], 0);
        chk($sformatf("%s dut%0d rdbk_valid", tag, k), rv[k], 0);
        chk($sformatf("%s dut%0d busy", tag, k), busy[k], 0);
        chk($sformatf("%s dut%0d done", tag, k), done[k], 0);
        chk($sformatf("%s dut%0d isol_n", tag, k), isol[k], 0);
    endtask

    // Per-cycle compare against the model's expected bitstream and readback words.
    always @(negedge prog_clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst[k] === 1'b0) begin
                chk($sformatf("dut%0d isol_n_eq_done", k), isol[k], done[k]);
                chk($sformatf("dut%0d busy_and_done", k), busy[k] & done[k], 0);
                if (busy[k]) busy_cnt[k]++;
                if (shen[k]) begin
                    shift_cnt[k]++;
                    got_head[k].push_back(head[k]);
                    chk($sformatf("dut%0d ready_in_shift", k), cfg_ready[k], 0);
                    if (exp_head[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected_shift: shift_en=1 with no bit left to shift", k);
                    end else begin
                        chk($sformatf("dut%0d ccff_head", k), head[k], exp_head[k].pop_front());
                    end
                end else begin
                    chk($sformatf("dut%0d head_when_idle", k), head[k], 0);
                end
                if (rv[k]) begin
                    rv_cnt[k]++;
                    got_rdbk[k].push_back(rd[k]);
                    if (exp_rdbk[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected_rdbk: rdbk_valid=1 data=%0h with none expected", k, rd[k]);
                    end else begin
                        chk($sformatf("dut%0d rdbk_data", k), rd[k], exp_rdbk[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic run_pass(input int k, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int bp, input bit poke);
        int         L;
        int         nw;
        int         t;
        logic [7:0] words [3];
        logic [7:0] w;
        logic [7:0] r;
        L  = len_of(k);
        nw = (L + 7) / 8;
        words[0] = w0; words[1] = w1; words[2] = w2;
        exp_head[k].delete();
        exp_rdbk[k].delete();
        for (int i = 0; i < L; i++) begin
            w = words[i / 8];
            exp_head[k].push_back(w[i % 8]);
        end
        for (int j = 0; j < nw; j++) begin
            r = '0;
            for (int b = 0; b < 8 && j * 8 + b < L; b++) r[b] = chain_q[k][j * 8 + b];
            exp_rdbk[k].push_back(r);
        end
        chain_q[k].delete();
        for (int i = 0; i < L; i++) chain_q[k].push_back(exp_head[k][i]);
        shift_cnt[k] = 0; busy_cnt[k] = 0; rv_cnt[k] = 0;
        got_head[k].delete(); got_rdbk[k].delete();

        start[k] = 1'b1; step(); start[k] = 1'b0;
        chk($sformatf("dut%0d start busy", k), busy[k], 1);
        chk($sformatf("dut%0d start done", k), done[k], 0);
        chk($sformatf("dut%0d start isol_n", k), isol[k], 0);
        chk($sformatf("dut%0d start cfg_ready", k), cfg_ready[k], 1);
        for (int j = 0; j < nw; j++) begin
            t = 0;
            while (cfg_ready[k] !== 1'b1 && t < 50) begin step(); t++; end
            chk($sformatf("dut%0d word%0d ready_timeout", k, j), cfg_ready[k], 1);
            if (j == 0) begin
                for (int c = 0; c < bp; c++) begin
                    chk($sformatf("dut%0d bp ready", k), cfg_ready[k], 1);
                    chk($sformatf("dut%0d bp shift_en", k), shen[k], 0);
                    step();
                end
            end
            cfg_valid[k] = 1'b1; cfg_data[k] = words[j];
            step();
            cfg_valid[k] = 1'b0; cfg_data[k] = 8'h5A;
            if (j == 0 && poke) begin
                start[k] = 1'b1; step(); start[k] = 1'b0;
            end
        end
        t = 0;
        while (done[k] !== 1'b1 && t < 100) begin step(); t++; end
        chk($sformatf("dut%0d done_timeout", k), done[k], 1);
        @(negedge prog_clk); #1;
        chk($sformatf("dut%0d end isol_n", k), isol[k], 1);
        chk($sformatf("dut%0d end busy", k), busy[k], 0);
        chk($sformatf("dut%0d end shift_en", k), shen[k], 0);
        chk($sformatf("dut%0d end cfg_ready", k), cfg_ready[k], 0);
        chk($sformatf("dut%0d shift_count", k), shift_cnt[k], L);
        chk($sformatf("dut%0d busy_cycles", k), busy_cnt[k], L + nw + bp);
        chk($sformatf("dut%0d rdbk_pulses", k), rv_cnt[k], nw);
        chk($sformatf("dut%0d head_left", k), exp_head[k].size(), 0);
        chk($sformatf("dut%0d rdbk_left", k), exp_rdbk[k].size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; abort_s[k] = 1'b0;
            cfg_valid[k] = 1'b0; cfg_data[k] = '0;
            shift_cnt[k] = 0; busy_cnt[k] = 0; rv_cnt[k] = 0;
            for (int i = 0; i < len_of(k); i++) chain_q[k].push_back(1'b0);
        end
        #1;
        for (int k = 0; k < NI; k++) chk_reset_vals(k, "reset");
        #10;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        step();

        // Basic load, then a second pass from DONE that reads the first one back.
        run_pass(0, 8'hA5, 8'h00, 8'h00, 0, 1'b0);
        chk("basic head_seq", pack_head(0), 32'h5);
        run_pass(0, 8'h0F, 8'h00, 8'h00, 0, 1'b0);
        chk("second head_seq", pack_head(0), 32'hF);
        chk("second rdbk_count", got_rdbk[0].size(), 1);
        chk("second rdbk_word", got_rdbk[0][0], 8'h05);

        // Multi-word with a start pulse mid-shift, then again with host backpressure.
        run_pass(1, 8'hFF, 8'h00, 8'hF3, 0, 1'b1);
        chk("multi head_seq", pack_head(1), 32'h300FF);
        chk("multi rdbk_last", got_rdbk[1][2], 8'h00);
        run_pass(1, 8'hFF, 8'h00, 8'hF3, 5, 1'b0);
        chk("multi2 rdbk_w0", got_rdbk[1][0], 8'hFF);
        chk("multi2 rdbk_w1", got_rdbk[1][1], 8'h00);
        chk("multi2 rdbk_w2", got_rdbk[1][2], 8'h03);

        // Abort after two shifted bits.
        exp_head[0].delete(); exp_rdbk[0].delete();
        for (int i = 0; i < 4; i++) exp_head[0].push_back(i[0] ^ i[1]);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        cfg_valid[0] = 1'b1; cfg_data[0] = 8'h06; step(); cfg_valid[0] = 1'b0;
        step(); step();
        chk("abort pre shift_en", shen[0], 1);
        abort_s[0] = 1'b1; step(); abort_s[0] = 1'b0;
        chk("abort shift_en", shen[0], 0);
        chk("abort busy", busy[0], 0);
        chk("abort done", done[0], 0);
        chk("abort isol_n", isol[0], 0);
        chk("abort cfg_ready", cfg_ready[0], 0);
        for (int c = 0; c < 3; c++) begin
            chk("abort no_rdbk", rv[0], 0);
            step();
        end
        exp_head[0].delete();
        resync_chain(0);

        // start together with abort in IDLE: abort wins.
        start[0] = 1'b1; abort_s[0] = 1'b1; step(); start[0] = 1'b0; abort_s[0] = 1'b0;
        chk("start_abort busy", busy[0], 0);
        chk("start_abort ready", cfg_ready[0], 0);

        // Asynchronous reset mid-shift, then a normal pass.
        exp_head[0].delete(); exp_rdbk[0].delete();
        for (int i = 0; i < 4; i++) exp_head[0].push_back(i[0] == 1'b0);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        cfg_valid[0] = 1'b1; cfg_data[0] = 8'hA5; step(); cfg_valid[0] = 1'b0;
        step(); step();
        #1 rst[0] = 1'b1;
        #1 chk_reset_vals(0, "async");
        #1 rst[0] = 1'b0;
        exp_head[0].delete(); exp_rdbk[0].delete();
        resync_chain(0);
        step();
        run_pass(0, 8'hA5, 8'h00, 8'h00, 0, 1'b0);
        chk("after_reset head_seq", pack_head(0), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
